// File: rtl/bicubic_phase_gen.sv
// bicubic_phase_gen: DDA coordinate/phase generator for the bicubic scaler.
// Emits per-output-pixel source tap (x1/y1) and Q8 blend over valid/ready.
module bicubic_phase_gen #(
    parameter int DIM_W   = 12,
    parameter int FRAC_W  = 16,
    parameter int BLEND_W = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIM_W-1:0]        src_w,
    input  logic [DIM_W-1:0]        src_h,
    input  logic [DIM_W-1:0]        out_w,
    input  logic [DIM_W-1:0]        out_h,
    input  logic [DIM_W+FRAC_W-1:0] step_x,
    input  logic [DIM_W+FRAC_W-1:0] step_y,
    input  logic                    dst_ready,
    output logic                    dst_valid,
    output logic [DIM_W-1:0]        src_x,
    output logic [BLEND_W-1:0]      x_blend,
    output logic [DIM_W-1:0]        src_y,
    output logic [BLEND_W-1:0]      y_blend,
    output logic                    line_start,
    output logic                    line_end,
    output logic                    frame_end,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int ACC_W = DIM_W + FRAC_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [DIM_W-1:0]   src_w_q, src_w_d;
    logic [DIM_W-1:0]   src_h_q, src_h_d;
    logic [DIM_W-1:0]   out_w_q, out_w_d;
    logic [DIM_W-1:0]   out_h_q, out_h_d;
    logic [ACC_W-1:0]   step_x_q, step_x_d;
    logic [ACC_W-1:0]   step_y_q, step_y_d;
    logic [ACC_W-1:0]   acc_x_q, acc_x_d;
    logic [ACC_W-1:0]   acc_y_q, acc_y_d;
    logic [DIM_W-1:0]   col_q, col_d;
    logic [DIM_W-1:0]   row_q, row_d;
    logic               valid_q, valid_d;
    logic [DIM_W-1:0]   src_x_q, src_x_d;
    logic [BLEND_W-1:0] x_blend_q, x_blend_d;
    logic [DIM_W-1:0]   src_y_q, src_y_d;
    logic [BLEND_W-1:0] y_blend_q, y_blend_d;
    logic               line_start_q, line_start_d;
    logic               line_end_q, line_end_d;
    logic               frame_end_q, frame_end_d;

    logic               load;
    logic               xfer;
    logic [ACC_W-1:0]   nx_acc_x;
    logic [ACC_W-1:0]   nx_acc_y;
    logic [DIM_W-1:0]   nx_col;
    logic [DIM_W-1:0]   nx_row;
    logic [DIM_W-1:0]   c_src_w;
    logic [DIM_W-1:0]   c_src_h;
    logic [DIM_W-1:0]   c_out_w;
    logic [DIM_W-1:0]   c_out_h;

    // Accumulators stick at all-ones rather than wrapping back to column 0.
    function automatic logic [ACC_W-1:0] sat_add(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b
    );
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    function automatic logic [DIM_W-1:0] map_int(
        input logic [ACC_W-1:0] acc,
        input logic [DIM_W-1:0] sz
    );
        logic [DIM_W-1:0] iv;
        logic [DIM_W-1:0] lim;
        iv  = acc[ACC_W-1:FRAC_W];
        lim = sz - DIM_W'(1);
        return (iv > lim) ? lim : iv;
    endfunction

    // Past the right/bottom edge the tap is pinned and the phase forced to 0.
    function automatic logic [BLEND_W-1:0] map_blend(
        input logic [ACC_W-1:0] acc,
        input logic [DIM_W-1:0] sz
    );
        logic [DIM_W-1:0]   iv;
        logic [DIM_W-1:0]   lim;
        logic [BLEND_W-1:0] b;
        iv     = acc[ACC_W-1:FRAC_W];
        lim    = sz - DIM_W'(1);
        b      = '0;
        b[7:0] = acc[FRAC_W-1 -: 8];
        return (iv > lim) ? '0 : b;
    endfunction

    // Next-state: frame FSM, raster walk and registered output fields.
    always_comb begin
        state_d      = state_q;
        src_w_d      = src_w_q;
        src_h_d      = src_h_q;
        out_w_d      = out_w_q;
        out_h_d      = out_h_q;
        step_x_d     = step_x_q;
        step_y_d     = step_y_q;
        acc_x_d      = acc_x_q;
        acc_y_d      = acc_y_q;
        col_d        = col_q;
        row_d        = row_q;
        valid_d      = valid_q;
        src_x_d      = src_x_q;
        x_blend_d    = x_blend_q;
        src_y_d      = src_y_q;
        y_blend_d    = y_blend_q;
        line_start_d = line_start_q;
        line_end_d   = line_end_q;
        frame_end_d  = frame_end_q;
        load         = 1'b0;
        nx_acc_x     = acc_x_q;
        nx_acc_y     = acc_y_q;
        nx_col       = col_q;
        nx_row       = row_q;
        xfer         = valid_q && dst_ready;

        // The first pixel is built from the live inputs as they are latched.
        if (state_q == S_IDLE) begin
            c_src_w = src_w;
            c_src_h = src_h;
            c_out_w = out_w;
            c_out_h = out_h;
        end else begin
            c_src_w = src_w_q;
            c_src_h = src_h_q;
            c_out_w = out_w_q;
            c_out_h = out_h_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_w_d  = src_w;
                    src_h_d  = src_h;
                    out_w_d  = out_w;
                    out_h_d  = out_h;
                    step_x_d = step_x;
                    step_y_d = step_y;
                    if (out_w != '0 && out_h != '0) begin
                        state_d  = S_RUN;
                        nx_acc_x = '0;
                        nx_acc_y = '0;
                        nx_col   = '0;
                        nx_row   = '0;
                        load     = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (xfer) begin
                    if (frame_end_q) begin
                        state_d      = S_DONE;
                        valid_d      = 1'b0;
                        acc_x_d      = '0;
                        acc_y_d      = '0;
                        col_d        = '0;
                        row_d        = '0;
                        src_x_d      = '0;
                        x_blend_d    = '0;
                        src_y_d      = '0;
                        y_blend_d    = '0;
                        line_start_d = 1'b0;
                        line_end_d   = 1'b0;
                        frame_end_d  = 1'b0;
                    end else if (line_end_q) begin
                        nx_acc_x = '0;
                        nx_acc_y = sat_add(acc_y_q, step_y_q);
                        nx_col   = '0;
                        nx_row   = row_q + DIM_W'(1);
                        load     = 1'b1;
                    end else begin
                        nx_acc_x = sat_add(acc_x_q, step_x_q);
                        nx_col   = col_q + DIM_W'(1);
                        load     = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            acc_x_d      = nx_acc_x;
            acc_y_d      = nx_acc_y;
            col_d        = nx_col;
            row_d        = nx_row;
            valid_d      = 1'b1;
            src_x_d      = map_int(nx_acc_x, c_src_w);
            x_blend_d    = map_blend(nx_acc_x, c_src_w);
            src_y_d      = map_int(nx_acc_y, c_src_h);
            y_blend_d    = map_blend(nx_acc_y, c_src_h);
            line_start_d = (nx_col == '0);
            line_end_d   = (nx_col == c_out_w - DIM_W'(1));
            frame_end_d  = (nx_col == c_out_w - DIM_W'(1)) &&
                           (nx_row == c_out_h - DIM_W'(1));
        end
    end

    // State and output registers; reset also aborts an in-flight frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_w_q      <= '0;
            src_h_q      <= '0;
            out_w_q      <= '0;
            out_h_q      <= '0;
            step_x_q     <= '0;
            step_y_q     <= '0;
            acc_x_q      <= '0;
            acc_y_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            valid_q      <= 1'b0;
            src_x_q      <= '0;
            x_blend_q    <= '0;
            src_y_q      <= '0;
            y_blend_q    <= '0;
            line_start_q <= 1'b0;
            line_end_q   <= 1'b0;
            frame_end_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_w_q      <= src_w_d;
            src_h_q      <= src_h_d;
            out_w_q      <= out_w_d;
            out_h_q      <= out_h_d;
            step_x_q     <= step_x_d;
            step_y_q     <= step_y_d;
            acc_x_q      <= acc_x_d;
            acc_y_q      <= acc_y_d;
            col_q        <= col_d;
            row_q        <= row_d;
            valid_q      <= valid_d;
            src_x_q      <= src_x_d;
            x_blend_q    <= x_blend_d;
            src_y_q      <= src_y_d;
            y_blend_q    <= y_blend_d;
            line_start_q <= line_start_d;
            line_end_q   <= line_end_d;
            frame_end_q  <= frame_end_d;
        end
    end

    assign dst_valid  = valid_q;
    assign src_x      = src_x_q;
    assign x_blend    = x_blend_q;
    assign src_y      = src_y_q;
    assign y_blend    = y_blend_q;
    assign line_start = line_start_q;
    assign line_end   = line_end_q;
    assign frame_end  = frame_end_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);

endmodule
